// File: rtl/frame_swap_ctrl.sv
// Ping-pong controller for two RGB frame buffers: the host fills the back buffer
// while scan-out reads the front buffer, and the two swap once a full frame is waiting.
module frame_swap_ctrl #(
   parameter int PIXELS = 10000,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [31:0]       wr_data,
   output logic              wr_ready,
   input  logic              rd_en,
   output logic              frame_start,
   output logic              swapped,
   output logic              pix_valid,
   output logic [7:0]        R,
   output logic [7:0]        G,
   output logic [7:0]        B,
   output logic              we0,
   output logic              re0,
   output logic [ADDR_W-1:0] addr0,
   output logic              we1,
   output logic              re1,
   output logic [ADDR_W-1:0] addr1,
   output logic [31:0]       wdata,
   input  logic [7:0]        r0,
   input  logic [7:0]        g0,
   input  logic [7:0]        b0,
   input  logic [7:0]        r1,
   input  logic [7:0]        g1,
   input  logic [7:0]        b1
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

   logic              frontSel_q, frontSel_d;
   logic              frontValid_q, frontValid_d;
   logic              backFull_q, backFull_d;
   logic [ADDR_W-1:0] wrCnt_q, wrCnt_d;
   logic [ADDR_W-1:0] rdCnt_q, rdCnt_d;
   logic              pixSel_q, pixSel_d;
   logic              pixValid_q;
   logic              swapped_q;

   logic wrAccept, rdIssue, endOfFrame, doSwap;

   always_ff @(posedge clk) begin
      if (reset) begin
         frontSel_q   <= 1'b0;
         frontValid_q <= 1'b0;
         backFull_q   <= 1'b0;
         wrCnt_q      <= '0;
         rdCnt_q      <= '0;
         pixSel_q     <= 1'b0;
         pixValid_q   <= 1'b0;
         swapped_q    <= 1'b0;
      end else begin
         frontSel_q   <= frontSel_d;
         frontValid_q <= frontValid_d;
         backFull_q   <= backFull_d;
         wrCnt_q      <= wrCnt_d;
         rdCnt_q      <= rdCnt_d;
         pixSel_q     <= pixSel_d;
         pixValid_q   <= rdIssue;
         swapped_q    <= doSwap;
      end
   end

   // The back buffer is always the one not selected as front, so we and re
   // can never land on the same buffer.
   always_comb begin
      wrAccept   = wr_valid && !backFull_q;
      rdIssue    = rd_en && frontValid_q;
      endOfFrame = rdIssue && (rdCnt_q == LAST);
      doSwap     = backFull_q && (endOfFrame || !frontValid_q);

      we0   = wrAccept && frontSel_q;
      we1   = wrAccept && !frontSel_q;
      re0   = rdIssue && !frontSel_q;
      re1   = rdIssue && frontSel_q;
      addr0 = '0;
      addr1 = '0;
      if (we0) addr0 = wrCnt_q;
      else if (re0) addr0 = rdCnt_q;
      if (we1) addr1 = wrCnt_q;
      else if (re1) addr1 = rdCnt_q;
      wdata       = wrAccept ? wr_data : 32'd0;
      wr_ready    = !backFull_q;
      frame_start = rdIssue && (rdCnt_q == '0);
   end

   // A swap only happens while back_full is set, so it never collides with a write accept.
   always_comb begin
      frontSel_d   = frontSel_q;
      frontValid_d = frontValid_q;
      backFull_d   = backFull_q;
      wrCnt_d      = wrCnt_q;
      rdCnt_d      = rdCnt_q;
      pixSel_d     = pixSel_q;
      if (wrAccept) begin
         if (wrCnt_q == LAST) begin
            wrCnt_d    = '0;
            backFull_d = 1'b1;
         end else begin
            wrCnt_d = wrCnt_q + 1'b1;
         end
      end
      if (rdIssue) begin
         pixSel_d = frontSel_q;
         rdCnt_d  = endOfFrame ? '0 : rdCnt_q + 1'b1;
      end
      if (doSwap) begin
         frontSel_d   = !frontSel_q;
         frontValid_d = 1'b1;
         backFull_d   = 1'b0;
         wrCnt_d      = '0;
      end
   end

   assign pix_valid = pixValid_q;
   assign swapped   = swapped_q;

   // pixSel_q remembers which buffer served the read, so a swap right after
   // the last read of a frame does not redirect that pixel.
   always_comb begin
      R = 8'd0;
      G = 8'd0;
      B = 8'd0;
      if (pixValid_q) begin
         R = pixSel_q ? r1 : r0;
         G = pixSel_q ? g1 : g0;
         B = pixSel_q ? b1 : b0;
      end
   end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Self-checking bench for frame_swap_ctrl with PIXELS=4: two buffer models,
// a frame-image reference model and a pixel scoreboard.
module tb_frame_swap_ctrl;

   localparam int NPIX = 4;
   localparam int AW   = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_valid = 1'b0;
   logic [31:0]   wr_data = 32'd0;
   logic          rd_en = 1'b0;
   logic          wr_ready, frame_start, swapped, pix_valid;
   logic [7:0]    R, G, B;
   logic          we0, re0, we1, re1;
   logic [AW-1:0] addr0, addr1;
   logic [31:0]   wdata;
   logic [7:0]    r0 = 8'd0, g0 = 8'd0, b0 = 8'd0;
   logic [7:0]    r1 = 8'd0, g1 = 8'd0, b1 = 8'd0;

   frame_swap_ctrl #(.PIXELS(NPIX), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_en(rd_en), .frame_start(frame_start), .swapped(swapped),
      .pix_valid(pix_valid), .R(R), .G(G), .B(B),
      .we0(we0), .re0(re0), .addr0(addr0),
      .we1(we1), .re1(re1), .addr1(addr1),
      .wdata(wdata),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1)
   );

   always #5 clk = ~clk;

   // Synchronous-read buffer models driven by the DUT's controls.
   logic [23:0] mem0 [NPIX];
   logic [23:0] mem1 [NPIX];
   always @(posedge clk) begin
      if (we0) mem0[addr0[1:0]] <= wdata[23:0];
      else if (re0) {r0, g0, b0} <= mem0[addr0[1:0]];
      if (we1) mem1[addr1[1:0]] <= wdata[23:0];
      else if (re1) {r1, g1, b1} <= mem1[addr1[1:0]];
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model: frame images move between front and back on a swap.
   logic [23:0] frontImg [NPIX];
   logic [23:0] backImg [NPIX];
   logic        mFrontSel, mFrontValid, mBackFull;
   int          mWrCnt, mRdCnt;
   logic [23:0] sbQ [$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mFrontSel = 1'b0;
      mFrontValid = 1'b0;
      mBackFull = 1'b0;
      mWrCnt = 0;
      mRdCnt = 0;
      sbQ.delete();
   endtask

   // One clock cycle: drive, check combinational controls, predict, then
   // check registered outputs and the scoreboarded pixel after the edge.
   task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic re);
      logic        wAcc, rIss, swp, expPv;
      logic [23:0] exp;
      logic [23:0] tmp;
      @(negedge clk);
      wr_valid = wv;
      wr_data = wd;
      rd_en = re;
      #1;
      wAcc = wv && !mBackFull;
      rIss = re && mFrontValid;
      swp = mBackFull && ((rIss && mRdCnt == NPIX - 1) || !mFrontValid);
      checkOutput("wr_ready", {31'd0, wr_ready}, {31'd0, !mBackFull});
      checkOutput("we", {30'd0, we1, we0}, wAcc ? (mFrontSel ? 32'd1 : 32'd2) : 32'd0);
      checkOutput("re", {30'd0, re1, re0}, rIss ? (mFrontSel ? 32'd2 : 32'd1) : 32'd0);
      checkOutput("frame_start", {31'd0, frame_start}, {31'd0, rIss && mRdCnt == 0});
      checkOutput("wdata", wdata, wAcc ? wd : 32'd0);
      checkOutput("backAddr", mFrontSel ? addr0 : addr1, wAcc ? mWrCnt : 0);
      checkOutput("frontAddr", mFrontSel ? addr1 : addr0, rIss ? mRdCnt : 0);
      if (rIss) sbQ.push_back(frontImg[mRdCnt]);
      expPv = rIss;
      if (wAcc) begin
         backImg[mWrCnt] = wd[23:0];
         if (mWrCnt == NPIX - 1) begin
            mWrCnt = 0;
            mBackFull = 1'b1;
         end else mWrCnt++;
      end
      if (rIss) mRdCnt = (mRdCnt == NPIX - 1) ? 0 : mRdCnt + 1;
      if (swp) begin
         for (int i = 0; i < NPIX; i++) begin
            tmp = frontImg[i];
            frontImg[i] = backImg[i];
            backImg[i] = tmp;
         end
         mFrontSel = !mFrontSel;
         mFrontValid = 1'b1;
         mBackFull = 1'b0;
         mWrCnt = 0;
      end
      @(posedge clk);
      #1;
      checkOutput("pix_valid", {31'd0, pix_valid}, {31'd0, expPv});
      checkOutput("swapped", {31'd0, swapped}, {31'd0, swp});
      if (expPv) begin
         if (sbQ.size() == 0) checkOutput("sbEmpty", 32'd1, 32'd0);
         else begin
            exp = sbQ.pop_front();
            checkOutput("pixel", {8'd0, R, G, B}, {8'd0, exp});
         end
      end else begin
         checkOutput("rgbIdle", {8'd0, R, G, B}, 32'd0);
      end
   endtask

   task automatic doReset(input logic re);
      @(negedge clk);
      reset = 1'b1;
      wr_valid = 1'b0;
      rd_en = re;
      @(posedge clk);
      #1;
      modelReset();
      checkOutput("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      checkOutput("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      checkOutput("rst_swapped", {31'd0, swapped}, 32'd0);
      checkOutput("rst_rgb", {8'd0, R, G, B}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic waitRdCnt(input int target);
      int n = 0;
      while (mRdCnt != target && n < 20) begin
         applyStimulus(1'b0, 32'd0, 1'b1);
         n++;
      end
      if (mRdCnt != target) checkOutput("alignTimeout", 32'd1, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) begin
         frontImg[i] = 24'd0;
         backImg[i] = 24'd0;
         mem0[i] = 24'd0;
         mem1[i] = 24'd0;
      end
      modelReset();

      // Reset and idle
      doReset(1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0);

      // First frame with rd_en held; initial fill swap then scan
      for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, 32'hFF00_0011 * 32'(i + 1) & 32'hFF00_00FF, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b1);

      // Second frame written while scanning
      for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, 32'h0000_00A0 + 32'(i), 1'b1);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'd0, 1'b1);

      // Last write coincides with end-of-frame
      for (int i = 0; i < NPIX - 1; i++) applyStimulus(1'b1, 32'h0012_3400 + 32'(i), 1'b1);
      waitRdCnt(NPIX - 1);
      applyStimulus(1'b1, 32'h0012_34FF, 1'b1);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'd0, 1'b1);

      // Back buffer full: held writes must be refused
      for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, 32'h0055_6600 + 32'(i), 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hAADE_ADBE, 1'b0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'd0, 1'b1);

      // Mixed traffic with random pixel data
      for (int i = 0; i < 24; i++)
         applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

      // Reset in mid-frame
      waitRdCnt(2);
      doReset(1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_swap_ctrl.md
# frame_swap_ctrl

Double-buffer (ping-pong) controller for the display adapter's two 24-bit RGB frame buffers. The host writes pixels into the back buffer while the scan-out side reads the front buffer sequentially. At the end of each scanned frame, the block swaps the two buffers if the back buffer holds a complete frame. It drives the read-enable, write-enable, address and write data of both buffer instances, and returns the scanned pixel with a valid flag.

## Interface
Parameters:
- PIXELS, 10000, pixels per frame; the buffer depth.
- ADDR_W, 20, address width of the buffers.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  host presents a pixel on wr_data.
- wr_data  in  32  host pixel; bits [23:0] are {R,G,B}, bits [31:24] are ignored.
- wr_ready  out  1  controller can accept a pixel this cycle.
- rd_en  in  1  scan-out requests one pixel this cycle.
- frame_start  out  1  one-cycle pulse when address 0 of the front buffer is issued.
- swapped  out  1  one-cycle pulse in the cycle after a swap takes effect.
- pix_valid  out  1  R/G/B carry a pixel read from the front buffer.
- R, G, B  out  8 each  scanned pixel, muxed from the selected buffer's outputs.
- we0, re0, addr0[ADDR_W], we1, re1, addr1[ADDR_W]  out  buffer 0/1 control.
- wdata  out  32  shared write data to both buffers.
- r0,g0,b0, r1,g1,b1  in  8 each  read data from buffer 0/1.

## Operation
- Buffer read model: with re=1 and we=0, the buffer presents the data at addr on its outputs after the next clk edge.
- Exclusivity: a buffer is either front (read only) or back (write only). we and re are never both 1 on the same buffer.
- State registers:
  - front_sel: 0 means buffer 0 is front.
  - front_valid: the front buffer holds a frame.
  - back_full
  - wr_cnt and rd_cnt: 0..PIXELS-1
- Write side:
  - wr_ready = !back_full.
  - A write is accepted when wr_valid && wr_ready. The back buffer's we=1, its addr=wr_cnt, wdata=wr_data, and wr_cnt increments.
  - The accept at wr_cnt==PIXELS-1 wraps wr_cnt to 0 and sets back_full on the next edge.
- Read side:
  - A read is issued when rd_en && front_valid. The front buffer's re=1, its addr=rd_cnt, and rd_cnt increments.
  - The read at rd_cnt==PIXELS-1 wraps rd_cnt to 0; this is end-of-frame.
  - frame_start is combinational: it is 1 when a read is issued with rd_cnt==0.
  - rd_en while front_valid=0 is ignored: no re, and pix_valid stays 0.
- Swap rules:
  - At end-of-frame with back_full=1 (as registered), on the next edge:
    - front_sel toggles;
    - back_full is cleared;
    - wr_cnt is set to 0;
    - front_valid=1.
  - At end-of-frame with back_full=0, there is no swap and the same front frame is scanned again (frame repeat).
  - Initial fill: while front_valid=0 and back_full=1, the swap happens on the next edge without waiting for end-of-frame.
  - The final host write and end-of-frame in the same cycle produce no swap this frame, because back_full is not yet set. The swap occurs at the following end-of-frame.
- Output mux: R/G/B come from buffer (front_sel_d ? 1 : 0). front_sel_d is front_sel registered alongside the issue of each read, so a pixel read just before a swap still comes from the old front buffer.
- When pix_valid=0, R/G/B are 0.
- Idle buffer controls: re, we and addr are 0. wdata is 0 when no write is accepted.

## Timing
- Reset values:
  - wr_ready=1 (back buffer is empty);
  - all other outputs 0 (frame_start, swapped, pix_valid, R/G/B, re/we/addr, wdata);
  - front_sel=0, front_valid=0, back_full=0, wr_cnt=0, rd_cnt=0.
- Write accept: single cycle, no latency; wr_ready falls on the edge after the PIXELS-th accept.
- Read latency: a read issued in cycle t gives pix_valid=1 and R/G/B in cycle t+1. Reads may be issued back to back at full throughput.
- Swap: end-of-frame in cycle t → front_sel flips and wr_ready=1 at t+1, swapped=1 in t+1, and a read in t+1 uses the new front buffer at address 0.
- Reset in mid-frame: everything returns to the reset state on that edge; any partial frame is discarded; pix_valid is 0 in the next cycle.

## Test plan
- Reset, then 3 idle cycles → wr_ready=1, pix_valid=0, all re/we=0, R/G/B=0.
- Use PIXELS=4 for these scenarios; write 0x11,0x22,0x33,0x44 and hold rd_en=1 → we1=1 at addr1=0..3. The swap then makes buffer 1 the front (first frame; front_sel toggles from 0 to 1), swapped pulses, and pix_valid=1 with B=0x11,0x22,0x33,0x44, with frame_start at the addr 0 issue.
- Write a second frame 0xA0..0xA3 while scanning → the first frame repeats until end-of-frame, then the swap occurs and the output shows 0xA0.. on the next scan with no glitch pixel.
- Issue the last host write in the same cycle as end-of-frame → no swap that frame, one repeat of the old frame, swap at the next end-of-frame.
- Hold wr_valid=1 with back_full=1 → wr_ready=0 and no we asserted; the buffer contents are unchanged after the swap.
- Assert reset at rd_cnt=2 → the next cycle gives pix_valid=0, wr_ready=1 and front_valid=0; later rd_en produces no re.
